// File: rtl/dcr_job_dispatch.sv
// dcr_job_dispatch: queues FFT/FIR/IIR job requests and issues them one at a
// time to the address calculator, waiting for the matching done under a
// watchdog, and reporting one completion record per job.
module dcr_job_dispatch #(
   parameter int              QDEPTH  = 4,
   parameter int              TO_W    = 16,
   parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [1:0]                 req_op,
   input  logic [31:0]                req_offset,
   input  logic [31:0]                req_filesize,
   output logic [31:0]                offset,
   output logic [31:0]                filesize,
   output logic                       fft_enable,
   output logic                       fir_enable,
   output logic                       iir_enable,
   input  logic                       fft_done,
   input  logic                       filt_done,
   output logic                       cmp_valid,
   output logic [1:0]                 cmp_op,
   output logic [1:0]                 cmp_status,
   output logic                       busy,
   output logic [$clog2(QDEPTH):0]    q_count
);

   localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

   localparam logic [1:0] OP_FFT = 2'b00;
   localparam logic [1:0] OP_FIR = 2'b01;
   localparam logic [1:0] OP_IIR = 2'b10;
   localparam logic [1:0] OP_BAD = 2'b11;

   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_TOUT = 2'b01;
   localparam logic [1:0] ST_REJ  = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [1:0]         q_op  [QDEPTH];
   logic [31:0]        q_off [QDEPTH];
   logic [31:0]        q_fs  [QDEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic               push, pop;
   logic [1:0]         job_op;
   logic [1:0]         status_r;
   logic               st_set;
   logic [1:0]         st_val;
   logic [TO_W-1:0]    wd;
   logic               illegal, match_done;

   assign req_ready  = (q_count != QFULL);
   assign push       = req_valid && req_ready;
   assign illegal    = (job_op == OP_BAD) || (filesize == 32'd0);
   // op 11 never reaches RUN, so it needs no done source here
   assign match_done = (job_op == OP_FFT) ? fft_done : filt_done;

   assign fft_enable = (state == S_RUN) && (job_op == OP_FFT);
   assign fir_enable = (state == S_RUN) && (job_op == OP_FIR);
   assign iir_enable = (state == S_RUN) && (job_op == OP_IIR);
   assign cmp_valid  = (state == S_DONE);
   assign cmp_op     = cmp_valid ? job_op   : 2'b00;
   assign cmp_status = cmp_valid ? status_r : 2'b00;
   assign busy       = (state != S_IDLE);

   // Request FIFO payload storage; contents are don't-care while empty
   always_ff @(posedge clk) begin
      if (push) begin
         q_op[wr_ptr]  <= req_op;
         q_off[wr_ptr] <= req_offset;
         q_fs[wr_ptr]  <= req_filesize;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   q_count <= q_count + CW'(1);
            2'b01:   q_count <= q_count - CW'(1);
            default: q_count <= q_count;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic, FIFO pop and completion status selection
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      st_set    = 1'b0;
      st_val    = ST_OK;
      case (state)
         S_IDLE: begin
            if (q_count != '0) begin
               pop       = 1'b1;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (illegal) begin
               st_set    = 1'b1;
               st_val    = ST_REJ;
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // done takes priority over a coincident watchdog expiry
            if (match_done) begin
               st_set    = 1'b1;
               st_val    = ST_OK;
               state_nxt = S_DONE;
            end else if (wd == TIMEOUT) begin
               st_set    = 1'b1;
               st_val    = ST_TOUT;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (q_count != '0) begin
               pop       = 1'b1;
               state_nxt = S_LOAD;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Job registers: loaded from the FIFO head on pop, held until the next pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         job_op   <= 2'b00;
         offset   <= 32'd0;
         filesize <= 32'd0;
      end else if (pop) begin
         job_op   <= q_op[rd_ptr];
         offset   <= q_off[rd_ptr];
         filesize <= q_fs[rd_ptr];
      end
   end

   // Completion status latched on entry to DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      status_r <= ST_OK;
      else if (st_set) status_r <= st_val;
   end

   // Watchdog: cleared in LOAD, counts in RUN and sticks at TIMEOUT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              wd <= '0;
      else if (state == S_LOAD)                wd <= '0;
      else if (state == S_RUN && wd != TIMEOUT) wd <= wd + TO_W'(1);
   end

endmodule

// File: tb/tb_dcr_job_dispatch.sv
// Directed testbench for dcr_job_dispatch (QDEPTH=4, TIMEOUT=20).
module tb_dcr_job_dispatch;

   localparam int          QDEPTH  = 4;
   localparam int          TO_W    = 16;
   localparam logic [15:0] TIMEOUT = 16'd20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_offset, req_filesize;
   logic [31:0] offset, filesize;
   logic        fft_enable, fir_enable, iir_enable;
   logic        fft_done, filt_done;
   logic        cmp_valid;
   logic [1:0]  cmp_op, cmp_status;
   logic        busy;
   logic [2:0]  q_count;

   int n_cmp = 0;
   int n_err = 0;

   dcr_job_dispatch #(.QDEPTH(QDEPTH), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_offset(req_offset), .req_filesize(req_filesize),
      .offset(offset), .filesize(filesize),
      .fft_enable(fft_enable), .fir_enable(fir_enable), .iir_enable(iir_enable),
      .fft_done(fft_done), .filt_done(filt_done),
      .cmp_valid(cmp_valid), .cmp_op(cmp_op), .cmp_status(cmp_status),
      .busy(busy), .q_count(q_count)
   );

   always #5 clk = ~clk;

   // Engine enables must be mutually exclusive at all times
   always @(negedge clk) begin
      n_cmp++;
      if ($countones({fft_enable, fir_enable, iir_enable}) > 1) begin
         n_err++;
         $display("FAIL enable_overlap: got %b want at most one high", {fft_enable, fir_enable, iir_enable});
      end
   end

   // Present one request for one clock edge (call and return on a negedge)
   task automatic push(input logic [1:0] op, input logic [31:0] off, input logic [31:0] fs);
      req_op = op; req_offset = off; req_filesize = fs; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Wait (bounded) for the selected enable: 0 fft, 1 fir, 2 iir
   task automatic wait_en(input int which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if ((which == 0 && fft_enable) || (which == 1 && fir_enable) || (which == 2 && iir_enable)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_offset = '0; req_filesize = '0;
      fft_done = 1'b0; filt_done = 1'b0;
      #1;
      n_cmp++; if (q_count !== 3'd0) begin n_err++; $display("FAIL rst_qcount: got %0d want 0", q_count); end
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if ({cmp_valid, cmp_op, cmp_status} !== 5'd0) begin n_err++; $display("FAIL rst_cmp: got %b want 00000", {cmp_valid, cmp_op, cmp_status}); end
      n_cmp++; if ({offset, filesize} !== 64'd0) begin n_err++; $display("FAIL rst_regs: got %h/%h want 0/0", offset, filesize); end
      n_cmp++; if ({fft_enable, fir_enable, iir_enable} !== 3'b000) begin n_err++; $display("FAIL rst_en: got %b want 000", {fft_enable, fir_enable, iir_enable}); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fft();
      int cnt;
      push(2'b00, 32'h1000, 32'h40);
      n_cmp++; if (q_count !== 3'd1) begin n_err++; $display("FAIL fft_q1: got %0d want 1", q_count); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fft_idle: got %b want 0", busy); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1 || fft_enable !== 1'b0) begin n_err++; $display("FAIL fft_load: got busy=%b en=%b want busy=1 en=0", busy, fft_enable); end
      n_cmp++; if (offset !== 32'h1000 || filesize !== 32'h40) begin n_err++; $display("FAIL fft_loadregs: got %h/%h want 1000/40", offset, filesize); end
      n_cmp++; if (q_count !== 3'd0) begin n_err++; $display("FAIL fft_q0: got %0d want 0", q_count); end
      @(negedge clk);
      n_cmp++; if (fft_enable !== 1'b1) begin n_err++; $display("FAIL fft_en_rise: got %b want 1", fft_enable); end
      cnt = 1;
      while (cnt < 10) begin
         @(negedge clk);
         n_cmp++; if (fft_enable !== 1'b1) begin n_err++; $display("FAIL fft_en_hold: got %b want 1 at cycle %0d", fft_enable, cnt + 1); end
         cnt++;
      end
      fft_done = 1'b1;
      @(negedge clk);
      fft_done = 1'b0;
      n_cmp++; if (fft_enable !== 1'b0) begin n_err++; $display("FAIL fft_en_fall: got %b want 0", fft_enable); end
      n_cmp++; if ({cmp_valid, cmp_op, cmp_status} !== 5'b1_00_00) begin n_err++; $display("FAIL fft_cmp: got %b want 10000", {cmp_valid, cmp_op, cmp_status}); end
      @(negedge clk);
      n_cmp++; if (cmp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL fft_after: got cmp=%b busy=%b want 0/0", cmp_valid, busy); end
      n_cmp++; if (offset !== 32'h1000 || filesize !== 32'h40) begin n_err++; $display("FAIL fft_keep: got %h/%h want 1000/40", offset, filesize); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      push(2'b01, 32'h100, 32'd1);
      wait_en(1, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_start: got no fir_enable want fir_enable within 40 cycles"); end
      for (int k = 1; k <= 4; k++) begin
         req_op = 2'b01; req_offset = 32'h100 * (k + 1); req_filesize = k + 1; req_valid = 1'b1;
         @(negedge clk);
      end
      req_valid = 1'b0;
      n_cmp++; if (q_count !== 3'd4 || req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: got q=%0d ready=%b want 4/0", q_count, req_ready); end
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (offset !== 32'h100 * (k + 1) || filesize !== k + 1) begin n_err++; $display("FAIL b2b_job%0d: got %h/%h want %h/%h", k, offset, filesize, 32'h100 * (k + 1), k + 1); end
         repeat (2) @(negedge clk);
         filt_done = 1'b1;
         @(negedge clk);
         filt_done = 1'b0;
         n_cmp++; if ({fir_enable, cmp_valid, cmp_op, cmp_status} !== 6'b0_1_01_00) begin n_err++; $display("FAIL b2b_cmp%0d: got %b want 010100", k, {fir_enable, cmp_valid, cmp_op, cmp_status}); end
         @(negedge clk);
         if (k < 4) begin
            n_cmp++; if (fir_enable !== 1'b0 || cmp_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_gap%0d: got en=%b cmp=%b busy=%b want 0/0/1", k, fir_enable, cmp_valid, busy); end
            @(negedge clk);
            n_cmp++; if (fir_enable !== 1'b1) begin n_err++; $display("FAIL b2b_next%0d: got %b want 1", k, fir_enable); end
         end else begin
            n_cmp++; if (busy !== 1'b0 || cmp_valid !== 1'b0 || q_count !== 3'd0) begin n_err++; $display("FAIL b2b_end: got busy=%b cmp=%b q=%0d want 0/0/0", busy, cmp_valid, q_count); end
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int cnt;
      push(2'b10, 32'h4000, 32'h20);
      wait_en(2, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL tout_start: got no iir_enable want iir_enable within 40 cycles"); end
      fft_done = 1'b1;
      cnt = 1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!iir_enable) break;
         cnt++;
      end
      fft_done = 1'b0;
      n_cmp++; if (cnt !== 21) begin n_err++; $display("FAIL tout_len: got %0d want 21", cnt); end
      n_cmp++; if ({cmp_valid, cmp_op, cmp_status} !== 5'b1_10_01) begin n_err++; $display("FAIL tout_cmp: got %b want 11001", {cmp_valid, cmp_op, cmp_status}); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tout_idle: got %b want 0", busy); end
   endtask

   task automatic test_illegal();
      req_op = 2'b11; req_offset = 32'hA000; req_filesize = 32'd8; req_valid = 1'b1;
      @(negedge clk);
      req_op = 2'b01; req_offset = 32'hB000; req_filesize = 32'd0;
      @(negedge clk);
      req_valid = 1'b0;
      n_cmp++; if (busy !== 1'b1 || cmp_valid !== 1'b0 || offset !== 32'hA000 || q_count !== 3'd1) begin n_err++; $display("FAIL ill_loadA: got busy=%b cmp=%b off=%h q=%0d want 1/0/a000/1", busy, cmp_valid, offset, q_count); end
      @(negedge clk);
      n_cmp++; if ({fft_enable, fir_enable, iir_enable, cmp_valid, cmp_op, cmp_status} !== 8'b000_1_11_10) begin n_err++; $display("FAIL ill_cmpA: got %b want 00011110", {fft_enable, fir_enable, iir_enable, cmp_valid, cmp_op, cmp_status}); end
      @(negedge clk);
      n_cmp++; if ({fft_enable, fir_enable, iir_enable, cmp_valid} !== 4'b0000 || offset !== 32'hB000 || filesize !== 32'd0) begin n_err++; $display("FAIL ill_loadB: got en/cmp=%b off=%h fs=%h want 0000/b000/0", {fft_enable, fir_enable, iir_enable, cmp_valid}, offset, filesize); end
      @(negedge clk);
      n_cmp++; if ({fft_enable, fir_enable, iir_enable, cmp_valid, cmp_op, cmp_status} !== 8'b000_1_01_10) begin n_err++; $display("FAIL ill_cmpB: got %b want 00010110", {fft_enable, fir_enable, iir_enable, cmp_valid, cmp_op, cmp_status}); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || cmp_valid !== 1'b0) begin n_err++; $display("FAIL ill_idle: got busy=%b cmp=%b want 0/0", busy, cmp_valid); end
   endtask

   task automatic test_reset_midjob();
      bit ok;
      push(2'b01, 32'h500, 32'd5);
      wait_en(1, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL mrst_start: got no fir_enable want fir_enable within 40 cycles"); end
      push(2'b01, 32'h600, 32'd6);
      push(2'b10, 32'h700, 32'd7);
      n_cmp++; if (q_count !== 3'd2 || fir_enable !== 1'b1) begin n_err++; $display("FAIL mrst_queued: got q=%0d en=%b want 2/1", q_count, fir_enable); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (q_count !== 3'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL mrst_ctrl: got q=%0d busy=%b ready=%b want 0/0/1", q_count, busy, req_ready); end
      n_cmp++; if ({fft_enable, fir_enable, iir_enable, cmp_valid, cmp_op, cmp_status} !== 8'd0) begin n_err++; $display("FAIL mrst_out: got %b want 00000000", {fft_enable, fir_enable, iir_enable, cmp_valid, cmp_op, cmp_status}); end
      n_cmp++; if ({offset, filesize} !== 64'd0) begin n_err++; $display("FAIL mrst_regs: got %h/%h want 0/0", offset, filesize); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (cmp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mrst_hold%0d: got cmp=%b busy=%b want 0/0", i, cmp_valid, busy); end
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || cmp_valid !== 1'b0 || q_count !== 3'd0) begin n_err++; $display("FAIL mrst_release: got busy=%b cmp=%b q=%0d want 0/0/0", busy, cmp_valid, q_count); end
      push(2'b00, 32'h2000, 32'h80);
      wait_en(0, ok);
      n_cmp++; if (!ok || offset !== 32'h2000 || filesize !== 32'h80) begin n_err++; $display("FAIL mrst_new: got ok=%b off=%h fs=%h want 1/2000/80", ok, offset, filesize); end
      repeat (2) @(negedge clk);
      fft_done = 1'b1;
      @(negedge clk);
      fft_done = 1'b0;
      n_cmp++; if ({fft_enable, cmp_valid, cmp_op, cmp_status} !== 6'b0_1_00_00) begin n_err++; $display("FAIL mrst_cmp: got %b want 010000", {fft_enable, cmp_valid, cmp_op, cmp_status}); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || cmp_valid !== 1'b0 || q_count !== 3'd0) begin n_err++; $display("FAIL mrst_end: got busy=%b cmp=%b q=%0d want 0/0/0", busy, cmp_valid, q_count); end
   endtask

   task automatic test_coincide();
      bit ok;
      int cnt;
      push(2'b01, 32'h3000, 32'h10);
      wait_en(1, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL coin_start: got no fir_enable want fir_enable within 40 cycles"); end
      cnt = 1;
      while (cnt < 21) begin
         @(negedge clk);
         n_cmp++; if (fir_enable !== 1'b1) begin n_err++; $display("FAIL coin_hold: got %b want 1 at cycle %0d", fir_enable, cnt + 1); end
         cnt++;
      end
      filt_done = 1'b1;
      @(negedge clk);
      filt_done = 1'b0;
      n_cmp++; if ({fir_enable, cmp_valid, cmp_op, cmp_status} !== 6'b0_1_01_00) begin n_err++; $display("FAIL coin_cmp: got %b want 010100", {fir_enable, cmp_valid, cmp_op, cmp_status}); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL coin_idle: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_fft();
      test_back_to_back();
      test_timeout();
      test_illegal();
      test_reset_midjob();
      test_coincide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion of sequence want finish before 200000 time units");
      $fatal(1, "bench time limit expired");
   end

endmodule

// File: doc/dcr_job_dispatch.md
# dcr_job_dispatch

Upstream sequencer for the address-calculation stage. Accepts job requests (FFT, FIR or IIR over a region given by offset and filesize), buffers them in a small FIFO, and presents one job at a time to the address calculator by driving its offset, filesize and engine enables. It then waits for the matching done, guarded by a watchdog, and emits a one-cycle completion record per job.

## Interface
- QDEPTH, 4: request FIFO depth, power of two, 2..16.
- TO_W, 16: watchdog counter width.
- TIMEOUT, 16'hFFFF: RUN cycles before a job is aborted; TIMEOUT < 2^TO_W.

Ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state on rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: FIFO can accept; = (q_count < QDEPTH).
- req_op, in, 2: 00 FFT, 01 FIR, 10 IIR, 11 illegal.
- req_offset, in, 32: region start address.
- req_filesize, in, 32: region length; 0 is illegal.
- offset, out, 32: registered offset to address calculator.
- filesize, out, 32: registered filesize to address calculator.
- fft_enable, fir_enable, iir_enable, out, 1 each: one-hot engine enables, held for the whole job.
- fft_done, filt_done, in, 1 each: completion from the address calculator. filt_done covers FIR and IIR.
- cmp_valid, out, 1: one-cycle completion pulse.
- cmp_op, out, 2: op of the completed job.
- cmp_status, out, 2: 00 ok, 01 timeout, 10 rejected (illegal op or zero filesize).
- busy, out, 1: FSM not in IDLE.
- q_count, out, $clog2(QDEPTH)+1: FIFO occupancy.

## Operation
- FIFO push on req_valid && req_ready. Entry holds {op, offset, filesize}.
- The FIFO pops only on FSM transitions into LOAD.
- FSM states:
  - IDLE: if q_count != 0, pop the head into the job registers and go to LOAD.
  - LOAD: offset/filesize outputs are valid and all enables are low (setup cycle).
    - Illegal job: go to DONE with status 10. No enable is ever asserted.
    - Legal job: clear the watchdog and go to RUN.
  - RUN: hold the selected enable high and increment the watchdog each cycle.
    - Matching done sampled high: go to DONE with status 00.
    - Watchdog == TIMEOUT: go to DONE with status 01.
  - DONE: all enables low; cmp_valid = 1 with cmp_op and cmp_status.
    - Next state is LOAD (with pop) if q_count != 0, else IDLE.
- Matching done: fft_done for op 00; filt_done for op 01/10. Non-matching done, and any done outside RUN, is ignored.
- If done and watchdog == TIMEOUT occur in the same cycle, done wins (status 00).
- offset/filesize keep the last job's values until the next LOAD.
- Push and pop in the same cycle are both honoured; q_count is unchanged. When the FIFO is full, req_ready is low, so no push occurs.
- Watchdog is TO_W bits and saturates at TIMEOUT. It does not wrap.

## Timing
- Reset (asserted asynchronously, at any time, including mid-job):
  - FIFO flushed, q_count = 0, FSM = IDLE.
  - offset = 0, filesize = 0; all enables = 0.
  - cmp_valid = 0, cmp_op = 0, cmp_status = 0, busy = 0, req_ready = 1 after reset.
  - No completion is reported for a job aborted by reset.
- Latency, for a request accepted at edge E0 into an empty FIFO with FSM in IDLE:
  - After E1: LOAD, offset/filesize valid.
  - After E2: RUN, enable high.
- Done sampled at edge En:
  - After En: enable low and cmp_valid high for exactly one cycle.
  - If another job is queued, its LOAD follows at En+1, with no extra IDLE cycle.
- Minimum enable-low gap between consecutive jobs is 2 cycles (DONE + LOAD).
- Timeout: enable is high for TIMEOUT+1 cycles, then DONE.
- Rejected job: LOAD then DONE, i.e. cmp_valid 2 cycles after the pop.
- Completions are in FIFO order. Each accepted request yields exactly one cmp_valid, unless reset intervenes.

## Test plan
- FFT job, offset=0x1000, filesize=0x40; bench raises fft_done 10 cycles after fft_enable rises. Required: fft_enable high exactly 10 cycles, then cmp_valid once with op 00, status 00; offset/filesize = 0x1000/0x40 from LOAD onward.
- Push 5 FIR jobs back-to-back with QDEPTH=4 while the first runs. Required: req_ready low when q_count=4; all 5 complete in order; enables are never overlapping; 2-cycle low gap between jobs.
- IIR job where the bench asserts only fft_done, with TIMEOUT=20. Required: fft_done ignored; iir_enable high 21 cycles; cmp_status 01, op 10.
- Illegal jobs, op=11 and then FIR with filesize=0. Required: no enable ever asserted; two cmp_valid pulses, status 10 each, 2 cycles after each pop.
- Deassert rst_n while in RUN with 2 jobs queued. Required: all outputs reach their reset values asynchronously, q_count=0, no cmp_valid; a new job after release runs normally.
- filt_done and watchdog==TIMEOUT coincide. Required: status 00.
